// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the two-requester switch-ALU arbiter and
//   the combinational ALU core.
//   Contents:
//     NREQ      number of requesters sharing the ALU (fixed at 2)
//     OP_W      width of an op code
//     alu_op_t  switch-ALU op codes, including the single illegal encoding
//     state_t   arbiter sequencing states
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned OP_W = 3;

    // Op codes of the switch ALU; 3'b110 and 3'b111 both subtract.
    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_ADD     = 3'b010,
        OP_ILLEGAL = 3'b011,
        OP_ANDN    = 3'b100,
        OP_ORN     = 3'b101,
        OP_SUB     = 3'b110,
        OP_SUB_ALT = 3'b111
    } alu_op_t;

    // Capture/grant, execute, hold result until consumed.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // True for op codes that carry/borrow out of the MSB.
    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SUB_ALT);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
//   Combinational NBITS-wide switch ALU. Used by the arbiter and by the LED
//   path in the board top so both see identical arithmetic.
//   Ports:
//     i_op        op code (alu_op_t)
//     i_a, i_b    operands
//     o_result_c  result, (op) mod 2^NBITS
//     o_carry_c   carry-out for ADD, borrow (A<B) for SUB, 0 otherwise
//     o_err_c     illegal op code; result and carry forced to 0
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned NBITS = 2
) (
    input  alu_op_t          i_op,
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    output logic [NBITS-1:0] o_result_c,
    output logic             o_carry_c,
    output logic             o_err_c
);

    localparam int unsigned EXT_W = NBITS + 1;

    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_diff;

    // Zero-extended so the top bit is the carry (sum) or the borrow (diff).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Op decode.
    always_comb begin
        o_result_c = '0;
        o_carry_c  = 1'b0;
        o_err_c    = 1'b0;
        case (i_op)
            OP_AND:     o_result_c = i_a & i_b;
            OP_OR:      o_result_c = i_a | i_b;
            OP_ADD: begin
                o_result_c = w_sum[NBITS-1:0];
                o_carry_c  = w_sum[NBITS];
            end
            OP_ANDN:    o_result_c = i_a & ~i_b;
            OP_ORN:     o_result_c = i_a | ~i_b;
            OP_SUB, OP_SUB_ALT: begin
                o_result_c = w_diff[NBITS-1:0];
                o_carry_c  = w_diff[NBITS];
            end
            OP_ILLEGAL: o_err_c = 1'b1;
            default:    o_err_c = 1'b1;
        endcase
    end

endmodule : alu_core

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one alu_core between two requesters (0 = switch panel,
//   1 = test/LCD engine) with round-robin arbitration. Each accepted op runs
//   IDLE -> EXEC -> RESP -> IDLE; ops never overlap.
//   Ports:
//     clk_2        system clock, rising edge
//     reset        synchronous, active-high; aborts any op, drops a pending result
//     req_valid    per-requester op present
//     req_ready    per-requester accept strobe (combinational, IDLE only)
//     req_op/a/b   per-requester op code and operands
//     resp_valid   result held for the consumer (RESP state)
//     resp_ready   consumer takes the result
//     resp_id      requester owning the result
//     resp_result  ALU result
//     resp_carry   carry (ADD) / borrow (SUB)
//     resp_err     illegal op code
//     busy         FSM not in IDLE
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned NBITS = 2,
    parameter int unsigned NREQ  = alu_pkg::NREQ
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][2:0]       req_op,
    input  logic [NREQ-1:0][NBITS-1:0] req_a,
    input  logic [NREQ-1:0][NBITS-1:0] req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_id,
    output logic [NBITS-1:0]           resp_result,
    output logic                       resp_carry,
    output logic                       resp_err,
    output logic                       busy
);

    import alu_pkg::*;

    // The grant logic is a single-bit round-robin; only two requesters are supported.
    if (NREQ != 2) begin : g_nreq_check
        $error("alu_arbiter: NREQ must be 2");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic             r_rr_ptr;
    logic             w_grant;
    logic             w_accept;

    alu_op_t          r_op;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic             r_id;

    logic [NBITS-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_err;

    logic             r_resp_valid;
    logic             r_resp_id;
    logic [NBITS-1:0] r_resp_result;
    logic             r_resp_carry;
    logic             r_resp_err;
    logic             r_busy;

    // Next state, grant selection and same-cycle ready.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_accept     = 1'b0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                // A lone requester wins outright; a tie goes to rr_ptr.
                if (!reset && (|req_valid)) begin
                    w_grant      = (&req_valid) ? r_rr_ptr : req_valid[1];
                    w_accept     = 1'b1;
                    req_ready    = NREQ'(1) << w_grant;
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Round-robin pointer: the loser of this grant has priority next tie.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_grant;
        end
    end

    // Operand capture at the request handshake.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_op <= OP_AND;
            r_a  <= '0;
            r_b  <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_op <= alu_op_t'(req_op[w_grant]);
            r_a  <= req_a[w_grant];
            r_b  <= req_b[w_grant];
            r_id <= w_grant;
        end
    end

    alu_core #(
        .NBITS (NBITS)
    ) u_alu_core (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result_c (w_alu_result),
        .o_carry_c  (w_alu_carry),
        .o_err_c    (w_alu_err)
    );

    // Result registers load in EXEC and hold until the next op's EXEC.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_carry  <= 1'b0;
            r_resp_err    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_resp_id     <= r_id;
            r_resp_result <= w_alu_result;
            r_resp_carry  <= w_alu_carry & is_arith(r_op);
            r_resp_err    <= w_alu_err;
        end
    end

    // resp_valid mirrors the RESP state; busy mirrors "not IDLE".
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_resp_valid <= (w_next_state == RESP);
            r_busy       <= (w_next_state != IDLE);
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_carry  = r_resp_carry;
    assign resp_err    = r_resp_err;
    assign busy        = r_busy;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Ops are queued per requester and driven by
//   a driver process; the expected response of each op is queued in grant
//   order and a monitor compares every response handshake against it.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned NBITS = 2;
    localparam int unsigned NREQ  = 2;

    typedef struct packed {
        logic [2:0]       op;
        logic [NBITS-1:0] a;
        logic [NBITS-1:0] b;
    } req_t;

    typedef struct packed {
        logic             id;
        logic [NBITS-1:0] result;
        logic             carry;
        logic             err;
    } resp_t;

    logic                       clk_2 = 1'b0;
    logic                       reset = 1'b1;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][2:0]       req_op = '0;
    logic [NREQ-1:0][NBITS-1:0] req_a = '0;
    logic [NREQ-1:0][NBITS-1:0] req_b = '0;
    logic                       resp_valid;
    logic                       resp_ready = 1'b1;
    logic                       resp_id;
    logic [NBITS-1:0]           resp_result;
    logic                       resp_carry;
    logic                       resp_err;
    logic                       busy;

    req_t  drv_q0[$];
    req_t  drv_q1[$];
    resp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .NBITS (NBITS),
        .NREQ  (NREQ)
    ) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue an op for requester r; optionally queue its expected response.
    task automatic send(input int r, input logic [2:0] op, input logic [1:0] a,
                        input logic [1:0] b, input bit has_resp, input logic id,
                        input logic [1:0] res, input logic c, input logic e);
        req_t  rq;
        resp_t rs;
        rq = '{op: op, a: a, b: b};
        if (r == 0) drv_q0.push_back(rq);
        else        drv_q1.push_back(rq);
        if (has_resp) begin
            rs = '{id: id, result: res, carry: c, err: e};
            exp_q.push_back(rs);
        end
    endtask

    // Wait until all queued work has drained and the DUT is idle.
    task automatic wait_quiet(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_2);
            if (drv_q0.size() == 0 && drv_q1.size() == 0 && exp_q.size() == 0 &&
                !busy && !resp_valid)
                done = 1'b1;
        end
        check(name, 8'(done), 8'd1);
    endtask

    // Driver: present the head of each queue, retire it after its handshake.
    initial begin : driver
        logic [NREQ-1:0] hs;
        forever begin
            @(negedge clk_2);
            hs = reset ? '0 : (req_valid & req_ready);
            @(posedge clk_2);
            #1;
            if (hs[0]) void'(drv_q0.pop_front());
            if (hs[1]) void'(drv_q1.pop_front());
            req_valid[0] = (drv_q0.size() != 0);
            req_valid[1] = (drv_q1.size() != 0);
            if (drv_q0.size() != 0) begin
                req_op[0] = drv_q0[0].op;
                req_a[0]  = drv_q0[0].a;
                req_b[0]  = drv_q0[0].b;
            end
            if (drv_q1.size() != 0) begin
                req_op[1] = drv_q1[0].op;
                req_a[1]  = drv_q1[0].a;
                req_b[1]  = drv_q1[0].b;
            end
        end
    end

    // Monitor: every response handshake is compared with the oldest expectation.
    always @(negedge clk_2) begin
        resp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got id=%0d result=%0d carry=%0d err=%0d expected none",
                         resp_id, resp_result, resp_carry, resp_err);
            end else begin
                e = exp_q.pop_front();
                check("resp", 8'({resp_id, resp_result, resp_carry, resp_err}), 8'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;

        // Reset state.
        repeat (2) @(negedge clk_2);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_resp_valid", 8'(resp_valid), 8'd0);
        check("rst_resp_fields", 8'({resp_id, resp_result, resp_carry, resp_err}), 8'd0);
        check("rst_ready", 8'(req_ready), 8'd0);
        @(posedge clk_2); #1 reset = 1'b0;
        @(negedge clk_2);
        check("idle_no_req_ready", 8'(req_ready), 8'd0);

        // 1: single ADD, same-cycle ready, two-edge latency.
        send(0, 3'b010, 2'd3, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        @(negedge clk_2);
        check("t1_ready", 8'(req_ready), 8'b01);
        check("t1_busy_idle", 8'(busy), 8'd0);
        @(negedge clk_2);
        check("t1_exec", 8'({resp_valid, busy, req_ready}), 8'b0100);
        @(negedge clk_2);
        check("t1_latency", 8'({resp_valid, busy}), 8'b11);
        wait_quiet("t1_drain");

        // 2: both valid from reset, grants alternate 0,1,0,1.
        @(posedge clk_2); #1 reset = 1'b1;
        @(posedge clk_2); #1 reset = 1'b0;
        @(negedge clk_2);
        send(0, 3'b000, 2'd3, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        send(1, 3'b110, 2'd1, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
        send(0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        send(1, 3'b001, 2'd1, 2'd2, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
        wait_quiet("t2_drain");

        // 3: illegal op, then the remaining op codes and wrap boundaries.
        @(negedge clk_2);
        send(1, 3'b011, 2'd3, 2'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        send(1, 3'b101, 2'd0, 2'd2, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        wait_quiet("t3a_drain");
        send(0, 3'b010, 2'd3, 2'd3, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        send(0, 3'b110, 2'd3, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        send(0, 3'b100, 2'd3, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        send(0, 3'b111, 2'd0, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        wait_quiet("t3b_drain");

        // 4: consumer stalls for 5 cycles in RESP.
        resp_ready = 1'b0;
        send(0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_2);
            seen = resp_valid;
        end
        check("t4_resp_seen", 8'(seen), 8'd1);
        send(1, 3'b001, 2'd2, 2'd1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_2);
            check("t4_hold", 8'({resp_valid, busy, req_ready, resp_id, resp_result}),
                  8'({1'b1, 1'b1, 2'b00, 1'b0, 2'd2}));
        end
        @(posedge clk_2); #1 resp_ready = 1'b1;
        @(negedge clk_2);
        check("t4_release_busy", 8'(busy), 8'd1);
        @(negedge clk_2);
        check("t4_idle", 8'({resp_valid, busy, req_ready}), 8'b0010);
        wait_quiet("t4_drain");

        // 5: reset during EXEC aborts the op and restores rr_ptr=0.
        @(negedge clk_2);
        send(0, 3'b000, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_2);
            seen = req_ready[0] & req_valid[0];
        end
        check("t5_accept", 8'(seen), 8'd1);
        @(posedge clk_2); #1 reset = 1'b1;
        @(negedge clk_2);
        check("t5_exec_busy", 8'(busy), 8'd1);
        @(negedge clk_2);
        check("t5_after_reset", 8'({busy, resp_valid, resp_id, resp_result, resp_carry, resp_err}), 8'd0);
        send(0, 3'b001, 2'd1, 2'd2, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        send(1, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        @(posedge clk_2); #1 reset = 1'b0;
        @(negedge clk_2);
        check("t5_grant0", 8'(req_ready), 8'b01);
        wait_quiet("t5_drain");

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_arbiter
